// File: rtl/riscv32ima_dec.sv
// RV32IMA decode stage: field split, immediate generation, register file read
// with writeback bypass/refresh, and a single registered output slot toward the ALU.

module riscv32ima_dec_src #(
  parameter int RAW = 5,
  parameter int RDW = 32,
  parameter int DW  = 64
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           load,
  input  logic           stall,
  input  logic [RAW-1:0] nxt_addr,
  input  logic [RDW-1:0] rf_rdata,
  input  logic           wen,
  input  logic [RAW-1:0] waddr,
  input  logic [RDW-1:0] wdata,
  output logic [RAW-1:0] addr,
  output logic [DW-1:0]  data
);
  logic wr_live;
  assign wr_live = wen && (waddr != '0);

  // A held operand keeps tracking writeback so the ALU never sees stale data.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      addr <= '0;
      data <= '0;
    end else if (load) begin
      addr <= nxt_addr;
      data <= DW'((wr_live && waddr == nxt_addr) ? wdata : rf_rdata);
    end else if (stall && wr_live && waddr == addr) begin
      data <= DW'(wdata);
    end
  end
endmodule

module riscv32ima_dec #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int INST_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      fetch_valid,
  output logic                      fetch_ready,
  input  logic [ADDR_WIDTH-1:0]     fetch_pc,
  input  logic [INST_WIDTH-1:0]     fetch_inst,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic [6:0]                dec_opcode,
  output logic [2:0]                dec_func3_opcode,
  output logic [6:0]                dec_func7_opcode,
  output logic [REG_ADDR_WIDTH-1:0] dec_src0_addr,
  output logic [REG_ADDR_WIDTH-1:0] dec_src1_addr,
  output logic [REG_ADDR_WIDTH-1:0] dec_dst_addr,
  output logic [ADDR_WIDTH-1:0]     dec_mem_addr,
  output logic [DATA_WIDTH-1:0]     dec_src0_data,
  output logic [DATA_WIDTH-1:0]     dec_src1_data,
  output logic [DATA_WIDTH-1:0]     dec_imm_data,
  output logic                      dec_illegal,
  input  logic                      wback_pc_wen,
  input  logic [ADDR_WIDTH-1:0]     wback_pc,
  input  logic                      wback_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wback_reg_addr,
  input  logic [REG_DATA_WIDTH-1:0] wback_reg_data
);
  localparam int NREG = 1 << REG_ADDR_WIDTH;

  localparam logic [6:0] OPC_LOAD      = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM  = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC     = 7'h17;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OPC_STORE     = 7'h23;
  localparam logic [6:0] OPC_AMO       = 7'h2F;
  localparam logic [6:0] OPC_OP        = 7'h33;
  localparam logic [6:0] OPC_LUI       = 7'h37;
  localparam logic [6:0] OPC_OP_32     = 7'h3B;
  localparam logic [6:0] OPC_BRANCH    = 7'h63;
  localparam logic [6:0] OPC_JALR      = 7'h67;
  localparam logic [6:0] OPC_JAL       = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM    = 7'h73;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

  typedef struct packed {
    logic [6:0]                op;
    logic [2:0]                f3;
    logic [6:0]                f7;
    logic [REG_ADDR_WIDTH-1:0] dst;
    logic [ADDR_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      ill;
  } dec_t;

  logic [REG_DATA_WIDTH-1:0] rf [NREG];
  fmt_e                      fmt;
  logic [31:0]               imm32;
  logic [6:0]                opc;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic [1:0][REG_ADDR_WIDTH-1:0] src_nxt, src_addr;
  logic [1:0][DATA_WIDTH-1:0]     src_data;
  logic [REG_ADDR_WIDTH-1:0] dst_nxt;
  dec_t                      dq, dnxt;
  logic                      xfer, load, stall;
  logic                      unused_wback_pc;

  assign unused_wback_pc = ^wback_pc;

  assign opc = fetch_inst[6:0];
  assign rs1 = fetch_inst[19:15];
  assign rs2 = fetch_inst[24:20];
  assign rd  = fetch_inst[11:7];

  always_comb begin
    fmt = FMT_X;
    case (opc)
      OPC_OP, OPC_OP_32, OPC_AMO:                       fmt = FMT_R;
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR,
      OPC_MISC_MEM, OPC_SYSTEM:                         fmt = FMT_I;
      OPC_STORE:                                        fmt = FMT_S;
      OPC_BRANCH:                                       fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                               fmt = FMT_U;
      OPC_JAL:                                          fmt = FMT_J;
      default:                                          fmt = FMT_X;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{fetch_inst[31]}}, fetch_inst[31:20]};
      FMT_S: imm32 = {{20{fetch_inst[31]}}, fetch_inst[31:25], fetch_inst[11:7]};
      FMT_B: imm32 = {{19{fetch_inst[31]}}, fetch_inst[31], fetch_inst[7],
                      fetch_inst[30:25], fetch_inst[11:8], 1'b0};
      FMT_U: imm32 = {fetch_inst[31:12], 12'b0};
      FMT_J: imm32 = {{11{fetch_inst[31]}}, fetch_inst[31], fetch_inst[19:12],
                      fetch_inst[20], fetch_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Fields the format does not use read as 0 so downstream hazard logic sees no false match.
  always_comb begin
    src_nxt[0] = (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) ? rs1 : '0;
    src_nxt[1] = (fmt inside {FMT_R, FMT_S, FMT_B})        ? rs2 : '0;
    dst_nxt    = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) ? rd  : '0;
  end

  always_comb begin
    dnxt.op  = opc;
    dnxt.f3  = fetch_inst[14:12];
    dnxt.f7  = fetch_inst[31:25];
    dnxt.dst = dst_nxt;
    dnxt.pc  = fetch_pc;
    dnxt.imm = {{(DATA_WIDTH-32){imm32[31]}}, imm32};
    dnxt.ill = (fetch_inst[1:0] != 2'b11) || (fmt == FMT_X);
  end

  assign fetch_ready = dec_ready | ~dec_valid;
  assign xfer        = fetch_valid & fetch_ready;
  assign load        = xfer & ~wback_pc_wen;
  assign stall       = dec_valid & ~dec_ready;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wback_reg_wen && wback_reg_addr != '0) begin
      rf[wback_reg_addr] <= wback_reg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      dec_valid <= 1'b0;
      dq        <= '0;
    end else if (wback_pc_wen) begin
      dec_valid <= 1'b0;
    end else if (fetch_ready) begin
      dec_valid <= fetch_valid;
      if (fetch_valid) dq <= dnxt;
    end
  end

  for (genvar n = 0; n < 2; n++) begin : g_src
    riscv32ima_dec_src #(
      .RAW(REG_ADDR_WIDTH), .RDW(REG_DATA_WIDTH), .DW(DATA_WIDTH)
    ) u_src (
      .clk      (clk),
      .nrst     (nrst),
      .load     (load),
      .stall    (stall),
      .nxt_addr (src_nxt[n]),
      .rf_rdata (rf[src_nxt[n]]),
      .wen      (wback_reg_wen),
      .waddr    (wback_reg_addr),
      .wdata    (wback_reg_data),
      .addr     (src_addr[n]),
      .data     (src_data[n])
    );
  end

  assign dec_opcode       = dq.op;
  assign dec_func3_opcode = dq.f3;
  assign dec_func7_opcode = dq.f7;
  assign dec_dst_addr     = dq.dst;
  assign dec_mem_addr     = dq.pc;
  assign dec_imm_data     = dq.imm;
  assign dec_illegal      = dq.ill;
  assign dec_src0_addr    = src_addr[0];
  assign dec_src1_addr    = src_addr[1];
  assign dec_src0_data    = src_data[0];
  assign dec_src1_data    = src_data[1];
endmodule
